// File: rtl/data_memory_byte_lane.sv
// data_memory_byte_lane
//   Byte-addressed RISC-V data memory in front of a 32-bit word array.
//   It supports LB/LH/LW/LBU/LHU and SB/SH/SW, with per-byte write lanes.
//   Requests and responses use valid/ready handshakes.
//   Only one access is in flight at a time (IDLE -> ACCESS -> RESP).
//
// Parameters
//   ADDR_BITS : word-address width; the array holds 2**ADDR_BITS words
//   INIT_FILE : hex image for the array ("" = none). Preloading the image is
//               left to the backing-array wrapper.
//
// Ports
//   clk, reset           : single rising-edge clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake (ready only in IDLE, low in reset)
//   req_write            : 1 = store, 0 = load
//   req_funct3           : RISC-V size/sign code
//   req_addr             : byte address
//   req_wdata            : right-aligned store data
//   rsp_valid/rsp_ready  : response handshake; outputs hold until accepted
//   rsp_rdata            : extended load data (0 for stores and errors)
//   rsp_err              : misaligned, illegal funct3 or (optional) out of range
//
// Optional feature macro: DATA_MEMORY_RANGE_CHECK_EN
//   Defined   : any set bit in req_addr[31:ADDR_BITS+2] flags an error.
//   Undefined : the upper address bits are ignored, so addresses alias.
module data_memory_byte_lane #(
  parameter int ADDR_BITS = 14,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 2**ADDR_BITS;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_nxt;

  logic [31:0]          mem [DEPTH];
  logic [ADDR_BITS-1:0] word_idx;
  logic [1:0]           byte_off;
  logic                 accept;
  logic                 range_err;
  logic                 err_p0;
  logic [3:0]           wr_en_p0;
  logic [31:0]          wr_data_p0;

  logic                 wr_p1;
  logic [2:0]           funct3_p1;
  logic [1:0]           off_p1;
  logic                 err_p1;
  logic [31:0]          rd_word_p1;

  // Illegal funct3 for the access type, or a size/offset misalignment.
  function automatic logic access_error(input logic       write,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    logic bad_f3;
    logic misal;
    if (write) bad_f3 = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
    else       bad_f3 = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                          f3 == 3'b100 || f3 == 3'b101);
    misal = ((f3[1:0] == 2'b01) && off[0]) ||
            ((f3[1:0] == 2'b10) && (off != 2'b00));
    return bad_f3 || misal;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data is replicated into every lane; the enables pick the live ones.
  function automatic logic [31:0] lane_data(input logic [2:0]  f3,
                                            input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  bs;
    logic signed [15:0] hs;
    logic signed [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h  = off[1] ? word[31:16] : word[15:0];
    bs = b;
    hs = h;
    case (f3)
      3'b000:  r = bs;
      3'b001:  r = hs;
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign word_idx  = req_addr[ADDR_BITS+1:2];
  assign byte_off  = req_addr[1:0];
  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_ready && req_valid;
  assign rsp_valid = (state == RESP);

`ifdef DATA_MEMORY_RANGE_CHECK_EN
  assign range_err = |req_addr[31:ADDR_BITS+2];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_BITS+2];
  assign range_err      = 1'b0;
`endif

  assign err_p0     = access_error(req_write, req_funct3, byte_off) || range_err;
  assign wr_en_p0   = (accept && req_write && !err_p0) ?
                      byte_enables(req_funct3, byte_off) : 4'b0000;
  assign wr_data_p0 = lane_data(req_funct3, req_wdata);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // p0 -> p1: acceptance edge. Stores commit here. The word read returns the
  // pre-write contents, which stores never use.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_word_p1 <= mem[word_idx];
      wr_p1      <= req_write;
      funct3_p1  <= req_funct3;
      off_p1     <= byte_off;
      err_p1     <= err_p0;
    end
    for (int i = 0; i < 4; i++) begin
      if (wr_en_p0[i]) mem[word_idx][8*i +: 8] <= wr_data_p0[8*i +: 8];
    end
  end

  // p1 -> rsp: ACCESS cycle forms the extended result; RESP holds it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state == ACCESS) begin
      rsp_rdata <= (err_p1 || wr_p1) ? 32'd0 : load_extend(rd_word_p1, funct3_p1, off_p1);
      rsp_err   <= err_p1;
    end
  end

endmodule
